// File: rtl/hub75_scan_controller_pkg.sv
// Shared types and width helpers for the HUB75 scan controller slice.
package hub75_pkg;

  // Scan sequencer states, in the order a plane is processed.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DISPLAY  = 3'd4
  } scan_state_t;

  // Width of an index over n items; never narrower than one bit so that
  // degenerate single-column or single-plane builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OE down-counter width: holds the longest plane time (last plane) with
  // one bit of headroom so the load value can never wrap.
  function automatic int oe_cnt_w(input int base, input int bits);
    return $clog2(base << (bits - 1)) + 1;
  endfunction

  // Default panel geometry (64x64 panel, 1/32 scan, 3-bit BCM).
  localparam int DEF_COLS     = 64;
  localparam int DEF_ROW_BITS = 5;
  localparam int DEF_BCM_BITS = 3;
  localparam int DEF_OE_BASE  = 32;

  localparam int DEF_COL_W    = idx_w(DEF_COLS);
  localparam int DEF_PLANE_W  = idx_w(DEF_BCM_BITS);
  localparam int DEF_OE_CNT_W = oe_cnt_w(DEF_OE_BASE, DEF_BCM_BITS);

endpackage

// File: rtl/hub75_scan_controller_if.sv
// Frame-buffer read port plus HUB75 panel pins, bundled for the scan controller.
interface hub75_scan_controller_if #(
  parameter int ROW_BITS = hub75_pkg::DEF_ROW_BITS,
  parameter int COL_W    = hub75_pkg::DEF_COL_W,
  parameter int PLANE_W  = hub75_pkg::DEF_PLANE_W
);

  // frame-buffer read port
  logic                      fb_rd_en;
  logic [ROW_BITS+COL_W-1:0] fb_addr;
  logic [PLANE_W-1:0]        fb_plane;
  logic [5:0]                fb_rgb;

  // panel pins
  logic [5:0]                hub75_rgb;
  logic                      hub75_clk;
  logic                      hub75_latch;
  logic                      hub75_oe_n;
  logic [ROW_BITS-1:0]       hub75_row;

  // controller side
  modport master (
    output fb_rd_en, fb_addr, fb_plane,
    input  fb_rgb,
    output hub75_rgb, hub75_clk, hub75_latch, hub75_oe_n, hub75_row
  );

  // frame-buffer / panel side
  modport slave (
    input  fb_rd_en, fb_addr, fb_plane,
    output fb_rgb,
    input  hub75_rgb, hub75_clk, hub75_latch, hub75_oe_n, hub75_row
  );

endinterface

// File: rtl/hub75_scan_controller_bcm_timer.sv
// BCM on-time timer: loads OE_BASE<<plane, counts down while running, done at 0.
module hub75_bcm_timer #(
  parameter int OE_BASE  = 32,
  parameter int PLANE_W  = 2,
  parameter int OE_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  logic [OE_CNT_W-1:0] cnt;

  // Down-counter; parks at zero so it can never underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= OE_CNT_W'(OE_BASE) << plane;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - OE_CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hub75_scan_controller.sv
// HUB75 scan sequencer: fetch a row's bit-plane, shift it out, latch, then BCM-weighted OE.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  ST_IDLE     | parked, panel dark; waits for en
//  ST_PREFETCH | request pixel pair for column 0 of current row/plane
//  ST_SHIFT    | two clk per column: A = load data (+ fetch next), B = clock edge
//  ST_LATCH    | latch shifted data, present new row address
//  ST_DISPLAY  | OE on for OE_BASE<<plane clk, then advance plane/row
//
// Panel pins are registered off the current state, so every pin event lands one
// clk after the state that produced it. This keeps data a full clk ahead of each
// shift-clock rising edge and keeps latch and OE-low in disjoint cycles.
module hub75_scan_controller
  import hub75_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int BCM_BITS = DEF_BCM_BITS,
  parameter int OE_BASE  = DEF_OE_BASE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    frame_done,
  hub75_scan_controller_if.master bus
);

  localparam int COL_W    = idx_w(COLS);
  localparam int PLANE_W  = idx_w(BCM_BITS);
  localparam int OE_CNT_W = oe_cnt_w(OE_BASE, BCM_BITS);

  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(BCM_BITS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

  scan_state_t state, state_nxt;

  logic [ROW_BITS-1:0] row;
  logic [COL_W-1:0]    col;
  logic [PLANE_W-1:0]  plane;
  logic                phase_b;

  logic                rd_en;
  logic [COL_W-1:0]    rd_col;
  logic                rd_en_q;
  logic [5:0]          pix_q;

  logic                timer_load;
  logic                timer_run;
  logic                timer_done;
  logic                plane_adv;
  logic                last_plane;

  logic [5:0]          rgb_q;
  logic                clk_q;
  logic                latch_q;
  logic                oe_n_q;
  logic [ROW_BITS-1:0] row_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, frame-buffer request and timer control.
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    rd_col     = '0;
    timer_load = 1'b0;
    timer_run  = 1'b0;
    plane_adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        rd_en      = 1'b1;
        timer_load = 1'b1;
        state_nxt  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!phase_b) begin
          if (col != COL_LAST) begin
            rd_en  = 1'b1;
            rd_col = col + COL_W'(1);
          end
        end else if (col == COL_LAST) begin
          state_nxt = ST_LATCH;
        end
      end
      // The timer starts counting here so DISPLAY lasts exactly the load value.
      ST_LATCH: begin
        timer_run = 1'b1;
        state_nxt = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        timer_run = 1'b1;
        if (timer_done) begin
          plane_adv = 1'b1;
          state_nxt = en ? ST_PREFETCH : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Column/phase and plane/row counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      plane   <= '0;
      phase_b <= 1'b0;
    end else begin
      if (state == ST_PREFETCH) begin
        col     <= '0;
        phase_b <= 1'b0;
      end else if (state == ST_SHIFT) begin
        phase_b <= ~phase_b;
        if (phase_b) col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
      end
      if (plane_adv) begin
        if (plane == PLANE_LAST) begin
          plane <= '0;
          row   <= row + ROW_BITS'(1);
        end else begin
          plane <= plane + PLANE_W'(1);
        end
      end
    end
  end

  // Pixel capture: the read issued in phase A returns during phase B, so it is
  // held in pix_q until the next phase A; column 0 arrives straight from PREFETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      rd_en_q <= rd_en;
      if (rd_en_q) pix_q <= bus.fb_rgb;
    end
  end

  // Registered panel pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      clk_q   <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      row_q   <= '0;
    end else begin
      if ((state == ST_SHIFT) && !phase_b) rgb_q <= rd_en_q ? bus.fb_rgb : pix_q;
      clk_q   <= (state == ST_SHIFT) && phase_b;
      latch_q <= (state == ST_LATCH);
      oe_n_q  <= (state != ST_DISPLAY);
      if (state == ST_LATCH) row_q <= row;
    end
  end

  hub75_bcm_timer #(
    .OE_BASE  (OE_BASE),
    .PLANE_W  (PLANE_W),
    .OE_CNT_W (OE_CNT_W)
  ) u_bcm_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .run   (timer_run),
    .plane (plane),
    .done  (timer_done)
  );

  assign last_plane = (plane == PLANE_LAST) && (row == ROW_LAST);
  assign frame_done = !rst && plane_adv && last_plane;

  assign bus.fb_rd_en    = rd_en && !rst;
  assign bus.fb_addr     = {row, rd_col};
  assign bus.fb_plane    = plane;
  assign bus.hub75_rgb   = rgb_q;
  assign bus.hub75_clk   = clk_q;
  assign bus.hub75_latch = latch_q;
  assign bus.hub75_oe_n  = oe_n_q;
  assign bus.hub75_row   = row_q;

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Self-checking bench: random frame-buffer contents and random en gaps, checked
// against an event-level panel model (shifted pixels per latch, row, OE length, frame end).
module tb_hub75_scan_controller;

  localparam int COLS     = 4;
  localparam int ROW_BITS = 2;
  localparam int BCM_BITS = 3;
  localparam int OE_BASE  = 4;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int COL_W    = 2;
  localparam int PLANE_W  = 2;

  logic clk;
  logic rst;
  logic en;
  logic frame_done;

  hub75_scan_controller_if #(
    .ROW_BITS (ROW_BITS),
    .COL_W    (COL_W),
    .PLANE_W  (PLANE_W)
  ) bus ();

  hub75_scan_controller #(
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .BCM_BITS (BCM_BITS),
    .OE_BASE  (OE_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_done (frame_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame buffer contents, one 6-bit pixel pair per {row,col} per plane
  logic [5:0] mem [BCM_BITS][ROWS*COLS];

  // frame-buffer read port: data one clk after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (bus.fb_rd_en) bus.fb_rgb <= mem[bus.fb_plane][bus.fb_addr];
    else              bus.fb_rgb <= 6'($urandom);
  end

  // panel model state (written only by the monitor)
  logic [5:0] shift_q[$];
  int   exp_row, exp_plane, oe_len, frames;
  bit   fd_flag, latched, prev_clk, prev_latch, prev_oe_n;
  logic [ROW_BITS-1:0] prev_row;
  int   clr_ack = 0;

  // control from the stimulus process
  int   clr_req = 0;
  bit   mon_on  = 0;

  // Panel monitor: reconstructs each plane from pin activity.
  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack   = clr_req;
      exp_row   = 0;
      exp_plane = 0;
      shift_q.delete();
      oe_len    = 0;
      fd_flag   = 0;
      latched   = 0;
      prev_clk  = 0;
      prev_latch = 0;
      prev_oe_n = 1;
      prev_row  = '0;
    end else if (mon_on && !rst) begin
      if (bus.hub75_clk && !prev_clk) shift_q.push_back(bus.hub75_rgb);
      if (bus.hub75_clk || bus.hub75_latch) check_eq("oe_off_during_load", bus.hub75_oe_n, 1);
      check_eq("fd_outside_oe", frame_done && bus.hub75_oe_n, 0);
      if (frame_done) frames++;
      if (bus.hub75_latch) begin
        check_eq("latch_width", prev_latch, 0);
        check_eq("latch_after_last_clk", prev_clk, 1);
        check_eq("latch_row", bus.hub75_row, exp_row);
        check_eq("clk_pulses", shift_q.size(), COLS);
        for (int i = 0; i < COLS && i < shift_q.size(); i++)
          check_eq($sformatf("pixel_r%0d_p%0d_c%0d", exp_row, exp_plane, i),
                   shift_q[i], mem[exp_plane][exp_row*COLS + i]);
        shift_q.delete();
        latched = 1;
      end else begin
        check_eq("row_hold", bus.hub75_row, prev_row);
      end
      if (prev_oe_n && !bus.hub75_oe_n) check_eq("oe_after_latch", latched, 1);
      if (!bus.hub75_oe_n) begin
        oe_len++;
        if (frame_done) fd_flag = 1;
      end
      if (!prev_oe_n && bus.hub75_oe_n) begin
        check_eq($sformatf("oe_len_p%0d", exp_plane), oe_len, OE_BASE << exp_plane);
        check_eq("frame_done", fd_flag, (exp_plane == BCM_BITS-1) && (exp_row == ROWS-1));
        oe_len  = 0;
        fd_flag = 0;
        latched = 0;
        if (exp_plane == BCM_BITS-1) begin
          exp_plane = 0;
          exp_row   = (exp_row + 1) % ROWS;
        end else begin
          exp_plane++;
        end
      end
      prev_clk   = bus.hub75_clk;
      prev_latch = bus.hub75_latch;
      prev_oe_n  = bus.hub75_oe_n;
      prev_row   = bus.hub75_row;
    end
  end

  int n;

  initial begin
    for (int p = 0; p < BCM_BITS; p++)
      for (int a = 0; a < ROWS*COLS; a++)
        mem[p][a] = 6'($urandom);
    rst = 1'b1;
    en  = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_oe_n",   bus.hub75_oe_n,  1);
    check_eq("rst_latch",  bus.hub75_latch, 0);
    check_eq("rst_clk",    bus.hub75_clk,   0);
    check_eq("rst_row",    bus.hub75_row,   0);
    check_eq("rst_rgb",    bus.hub75_rgb,   0);
    check_eq("rst_rd_en",  bus.fb_rd_en,    0);
    check_eq("rst_fdone",  frame_done,      0);

    // released with en=0: stays dark
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_eq("idle_oe_n",  bus.hub75_oe_n,  1);
      check_eq("idle_latch", bus.hub75_latch, 0);
      check_eq("idle_clk",   bus.hub75_clk,   0);
      check_eq("idle_row",   bus.hub75_row,   0);
    end

    // start: first shift-clock rising edge 3 clk after leaving IDLE
    clr_req++;
    mon_on = 1;
    en     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.hub75_clk && n < 20);
    check_eq("first_clk_latency", n, 4);

    // continuous run across several frames
    repeat (700) @(negedge clk);

    // en dropped during SHIFT: plane finishes, then parks dark
    n = 0;
    while (!bus.hub75_clk && n < 200) begin @(negedge clk); n++; end
    check_eq("drop_in_shift", bus.hub75_clk, 1);
    en = 1'b0;
    n = 0;
    while (bus.hub75_oe_n && n < 200) begin @(negedge clk); n++; end
    check_eq("drop_oe_opens", bus.hub75_oe_n, 0);
    n = 0;
    while (!bus.hub75_oe_n && n < 200) begin @(negedge clk); n++; end
    check_eq("drop_oe_closes", bus.hub75_oe_n, 1);
    repeat (30) begin
      @(negedge clk);
      check_eq("parked_clk",   bus.hub75_clk,   0);
      check_eq("parked_latch", bus.hub75_latch, 0);
      check_eq("parked_oe_n",  bus.hub75_oe_n,  1);
      check_eq("parked_rd_en", bus.fb_rd_en,    0);
    end

    // reset in DISPLAY: dark next clk, no latch, restart from row 0 plane 0
    en = 1'b1;
    n = 0;
    while (bus.hub75_oe_n && n < 200) begin @(negedge clk); n++; end
    check_eq("disp_before_rst", bus.hub75_oe_n, 0);
    repeat (2) @(negedge clk);
    mon_on = 0;
    rst    = 1'b1;
    @(negedge clk);
    check_eq("rst_disp_oe_n", bus.hub75_oe_n, 1);
    check_eq("rst_disp_row",  bus.hub75_row,  0);
    check_eq("rst_disp_clk",  bus.hub75_clk,  0);
    repeat (2) begin
      check_eq("rst_disp_latch", bus.hub75_latch, 0);
      @(negedge clk);
    end
    clr_req++;
    rst    = 1'b0;
    mon_on = 1;

    // random en gaps over many planes
    for (int k = 0; k < 12; k++) begin
      en = 1'b1;
      repeat ($urandom_range(30, 300)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    en = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("end_oe_n",        bus.hub75_oe_n, 1);
    check_eq("end_no_partial",  shift_q.size(), 0);
    check_eq("frames_seen",     frames >= 2,    1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
